// File: rtl/neuron_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_scheduler
//  Purpose  : Sequences one integrate-and-fire timestep over NEURON_NUM
//             membrane voltages held in an external single-port memory, or
//             sweeps that memory to zero. Each neuron takes a read cycle (RD)
//             followed by a write-back cycle (WR) that adds the synaptic
//             current with saturation and applies reset-by-subtraction
//             when the threshold is reached.
//  Ports    :
//    clk          in   1   clock, rising edge
//    rst_n        in   1   asynchronous active-low reset
//    start        in   1   pulse: run one timestep (ignored while busy)
//    clear        in   1   pulse: zero all voltages (wins over start)
//    syn_current  in  16   signed input current for neuron at mem_addr (WR)
//    mem_rdata    in  16   signed voltage, one-cycle registered read latency
//    mem_wr_en    out  1   memory write enable (0 = read)
//    mem_addr     out  6   memory neuron address
//    mem_wdata    out 16   signed voltage to write
//    busy         out  1   high whenever not IDLE
//    done         out  1   one-cycle pulse in FIN
//    spike_valid  out  1   one-cycle pulse per firing neuron
//    spike_idx    out  6   index of firing neuron
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_scheduler #(
    parameter int                 NEURON_NUM = 40,
    parameter logic signed [15:0] THRESHOLD  = 16'sd256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear,
    input  logic signed [15:0] syn_current,
    input  logic signed [15:0] mem_rdata,
    output logic               mem_wr_en,
    output logic [5:0]         mem_addr,
    output logic signed [15:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               spike_valid,
    output logic [5:0]         spike_idx
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_CLR  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [5:0] c_last_idx = 6'(NEURON_NUM - 1);

    logic [2:0]         r_state;
    logic [5:0]         r_idx;
    logic               r_wr_en;
    logic               r_busy;
    logic               r_done;
    logic               r_spike_valid;
    logic [5:0]         r_spike_idx;

    logic signed [16:0] w_sum;
    logic signed [15:0] w_sat;
    logic               w_fire;
    logic signed [15:0] w_update;

    // 17-bit sum cannot overflow; bits 16 and 15 disagree only when the
    // 16-bit result would, and bit 16 then gives the direction.
    assign w_sum = {mem_rdata[15], mem_rdata} + {syn_current[15], syn_current};

    always_comb begin
        w_sat = w_sum[15:0];
        if (w_sum[16] != w_sum[15]) begin
            w_sat = w_sum[16] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    // THRESHOLD is positive, so subtracting it from a value at or above it
    // stays in range.
    assign w_fire   = (w_sat >= THRESHOLD);
    assign w_update = w_fire ? (w_sat - THRESHOLD) : w_sat;

    // Write data depends on mem_rdata, which only becomes valid inside the
    // WR cycle, so it is decoded from the registered state rather than
    // registered itself.
    always_comb begin
        mem_wdata = 16'sd0;
        if (r_state == S_WR) begin
            mem_wdata = w_update;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= 6'd0;
            r_wr_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_spike_valid <= 1'b0;
            r_spike_idx   <= 6'd0;
        end else begin
            r_done        <= 1'b0;
            r_spike_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx <= 6'd0;
                    if (clear) begin
                        r_state <= S_CLR;
                        r_wr_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (start) begin
                        r_state <= S_RD;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RD: begin
                    r_state <= S_WR;
                    r_wr_en <= 1'b1;
                end
                S_WR: begin
                    if (w_fire) begin
                        r_spike_valid <= 1'b1;
                        r_spike_idx   <= r_idx;
                    end
                    r_wr_en <= 1'b0;
                    if (r_idx == c_last_idx) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RD;
                        r_idx   <= r_idx + 6'd1;
                    end
                end
                S_CLR: begin
                    if (r_idx == c_last_idx) begin
                        r_state <= S_FIN;
                        r_wr_en <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_idx   <= 6'd0;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= 6'd0;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wr_en   = r_wr_en;
    assign mem_addr    = r_idx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign spike_valid = r_spike_valid;
    assign spike_idx   = r_spike_idx;

endmodule
`default_nettype wire

// File: tb/tb_neuron_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_scheduler
//  Purpose  : Directed self-checking bench for neuron_scheduler with a
//             behavioural 64-entry memory (registered read).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_scheduler;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               clear;
    logic signed [15:0] syn_current;
    logic signed [15:0] mem_rdata;
    logic               mem_wr_en;
    logic [5:0]         mem_addr;
    logic signed [15:0] mem_wdata;
    logic               busy;
    logic               done;
    logic               spike_valid;
    logic [5:0]         spike_idx;

    int checks;
    int failures;

    neuron_scheduler #(
        .NEURON_NUM (40),
        .THRESHOLD  (16'sd256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear       (clear),
        .syn_current (syn_current),
        .mem_rdata   (mem_rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; preload fills every entry in one edge.
    logic signed [15:0] mem [64];
    logic               preload_en;
    logic signed [15:0] preload_val;

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= preload_val;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Activity monitors, sampled on the falling edge.
    int mon_busy_nd;
    int mon_done;
    int mon_spikes;
    int mon_order_err;
    int mon_next_idx;
    int mon_writes;
    int mon_nz_writes;

    always @(negedge clk) begin
        if (busy && !done) mon_busy_nd++;
        if (done) mon_done++;
        if (spike_valid) begin
            if (int'(spike_idx) != mon_next_idx) mon_order_err++;
            mon_next_idx++;
            mon_spikes++;
        end
        if (mem_wr_en) begin
            mon_writes++;
            if (mem_wdata != 16'sd0) mon_nz_writes++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        mon_busy_nd   = 0;
        mon_done      = 0;
        mon_spikes    = 0;
        mon_order_err = 0;
        mon_next_idx  = 0;
        mon_writes    = 0;
        mon_nz_writes = 0;
    endtask

    task automatic preload(input logic signed [15:0] v);
        @(negedge clk);
        #1;
        preload_val = v;
        preload_en  = 1'b1;
        @(negedge clk);
        #1;
        preload_en  = 1'b0;
    endtask

    task automatic launch(input logic s, input logic c);
        @(negedge clk);
        #1;
        clr_cnt();
        start = s;
        clear = c;
        @(negedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout observed=no_done expected=done", tag);
        end
        @(negedge clk);
        #1;
    endtask

    // Counts entries 0..39 that differ from the expected value.
    function automatic int mem_bad(input logic signed [15:0] v);
        int bad;
        bad = 0;
        for (int i = 0; i < 40; i++) if (mem[i] !== v) bad++;
        return bad;
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        clear       = 1'b0;
        syn_current = 16'sd0;
        preload_val = 16'sd123;
        preload_en  = 1'b1;
        clr_cnt();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_addr",  int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        check("rst_spike", int'(spike_valid), 0);
        check("rst_sidx",  int'(spike_idx), 0);
        #1;
        preload_en = 1'b0;
        rst_n      = 1'b1;

        // Clear sweep: 40 zero writes, entry 40 untouched
        launch(1'b0, 1'b1);
        wait_done("clr");
        check("clr_writes", mon_writes, 40);
        check("clr_nz",     mon_nz_writes, 0);
        check("clr_busy",   mon_busy_nd, 40);
        check("clr_done",   mon_done, 1);
        check("clr_spikes", mon_spikes, 0);
        check("clr_mem",    mem_bad(16'sd0), 0);
        check("clr_nowrap", int'(mem[40]), 123);

        // Three timesteps with current 100
        syn_current = 16'sd100;
        launch(1'b1, 1'b0);
        wait_done("st1");
        check("st1_spikes", mon_spikes, 0);
        check("st1_mem",    mem_bad(16'sd100), 0);
        check("st1_busy",   mon_busy_nd, 80);
        check("st1_writes", mon_writes, 40);
        check("st1_done",   mon_done, 1);
        check("st1_nowrap", int'(mem[40]), 123);

        launch(1'b1, 1'b0);
        wait_done("st2");
        check("st2_spikes", mon_spikes, 0);
        check("st2_mem",    mem_bad(16'sd200), 0);

        launch(1'b1, 1'b0);
        wait_done("st3");
        check("st3_spikes", mon_spikes, 40);
        check("st3_order",  mon_order_err, 0);
        check("st3_mem",    mem_bad(16'sd44), 0);
        check("st3_mem0",   int'(mem[0]), 44);

        // Positive saturation then fire
        preload(16'sd32760);
        launch(1'b1, 1'b0);
        wait_done("psat");
        check("psat_mem",    int'(mem[5]), 32511);
        check("psat_all",    mem_bad(16'sd32511), 0);
        check("psat_spikes", mon_spikes, 40);

        // Negative saturation, no fire
        preload(-16'sd32760);
        syn_current = -16'sd100;
        launch(1'b1, 1'b0);
        wait_done("nsat");
        check("nsat_mem",    int'(mem[39]), -32768);
        check("nsat_all",    mem_bad(-16'sd32768), 0);
        check("nsat_spikes", mon_spikes, 0);

        // start and clear together: clear wins
        preload(16'sd300);
        syn_current = 16'sd100;
        launch(1'b1, 1'b1);
        wait_done("both");
        check("both_writes", mon_writes, 40);
        check("both_nz",     mon_nz_writes, 0);
        check("both_spikes", mon_spikes, 0);
        check("both_busy",   mon_busy_nd, 40);
        check("both_mem",    mem_bad(16'sd0), 0);

        // start / clear while busy are ignored
        launch(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        clear = 1'b1;
        @(negedge clk);
        #1;
        clear = 1'b0;
        wait_done("busy_ign");
        repeat (5) @(negedge clk);
        check("ign_busy",  mon_busy_nd, 80);
        check("ign_done",  mon_done, 1);
        check("ign_idle",  int'(busy), 0);
        check("ign_mem",   mem_bad(16'sd100), 0);

        // Asynchronous reset during WR of neuron 17
        syn_current = 16'sd0;
        launch(1'b1, 1'b0);
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 200 && !hit; k++) begin
                @(negedge clk);
                if (mem_wr_en && mem_addr == 6'd17) hit = 1'b1;
            end
            check("arst_reach17", int'(hit), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  int'(busy), 0);
        check("arst_wr_en", int'(mem_wr_en), 0);
        check("arst_addr",  int'(mem_addr), 0);
        check("arst_wdata", int'(mem_wdata), 0);
        check("arst_spike", int'(spike_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_nodone", mon_done, 0);

        preload(16'sd0);
        syn_current = 16'sd300;
        launch(1'b1, 1'b0);
        wait_done("post_rst");
        check("prst_spikes", mon_spikes, 40);
        check("prst_order",  mon_order_err, 0);
        check("prst_writes", mon_writes, 40);
        check("prst_mem",    mem_bad(16'sd44), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 SHALL have parameter NEURON_NUM, default 40, number of neurons sequenced (1..64).
REQ-002 SHALL have parameter THRESHOLD, default 16'sd256, signed firing threshold (>0).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  pulse: run one timestep over all neurons.
REQ-006 SHALL have port clear  input  1  pulse: zero every stored membrane voltage.
REQ-007 SHALL have port syn_current  input  16  signed input current for neuron at mem_addr, valid in WR state.
REQ-008 SHALL have port mem_rdata  input  16  signed voltage from memory, 1-cycle registered read latency.
REQ-009 SHALL have port mem_wr_en  output  1  memory write enable; low means read.
REQ-010 SHALL have port mem_addr  output  6  memory neuron address.
REQ-011 SHALL have port mem_wdata  output  16  signed voltage to write.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of timestep or clear sweep.
REQ-014 SHALL have port spike_valid  output  1  one-cycle pulse per firing neuron.
REQ-015 SHALL have port spike_idx  output  6  index of firing neuron, valid with spike_valid.

Function
REQ-016 SHALL implement states IDLE, RD, WR, CLR, FIN.
REQ-017 IDLE: clear=1 -> CLR with index 0; else start=1 -> RD with index 0; else stay; clear has priority when both high.
REQ-018 start and clear SHALL be ignored while busy=1.
REQ-019 RD: mem_wr_en=0, mem_addr=index; next state WR.
REQ-020 WR: mem_wr_en=1, mem_addr=index, mem_wdata=update(mem_rdata, syn_current); index==NEURON_NUM-1 -> FIN, else index+1 and RD.
REQ-021 update: sum = mem_rdata + syn_current in 17-bit signed, saturated to [-32768, 32767].
REQ-022 If saturated sum >= THRESHOLD, wdata = sum - THRESHOLD (reset by subtraction) and neuron fires; else wdata = sum.
REQ-023 Firing in WR for index n SHALL give spike_valid=1, spike_idx=n in the following cycle only.
REQ-024 CLR: mem_wr_en=1, mem_addr=index, mem_wdata=0; last index -> FIN, else index+1.
REQ-025 FIN: done=1 for exactly one cycle, mem_wr_en=0; next state IDLE.
REQ-026 A timestep SHALL take 2*NEURON_NUM cycles from the first RD to the last WR; done follows in the next cycle.
REQ-027 A clear sweep SHALL take NEURON_NUM cycles plus one FIN cycle.
REQ-028 Addresses SHALL be issued in ascending order 0..NEURON_NUM-1 with no wrap beyond NEURON_NUM-1.
REQ-029 mem_wr_en SHALL be 0 in IDLE and FIN; no write outside WR and CLR.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, index=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, done=0, spike_valid=0, spike_idx=0.
REQ-031 Reset mid-timestep or mid-clear SHALL abort the sweep; memory contents are not restored and no done pulse is issued.
REQ-032 After release, the block SHALL accept start/clear in the first cycle it is in IDLE.

Verification
REQ-033 Clear, then three starts with syn_current=100 for all neurons -> steps 1 and 2: no spikes, stored 100 then 200; step 3: 40 spikes, idx 0..39, stored 44.
REQ-034 Memory preloaded 32760, syn_current=100 -> sum saturates to 32767, spike, wdata=32511.
REQ-035 Memory preloaded -32760, syn_current=-100 -> wdata=-32768, no spike.
REQ-036 start and clear in the same IDLE cycle -> clear sweep runs: 40 writes of 0, then done; no spikes.
REQ-037 start pulsed during a running timestep -> ignored; exactly 80 busy cycles, then a single done.
REQ-038 rst_n low at neuron 17 WR -> outputs zero asynchronously; after release, a start runs a full sweep from index 0.
